// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the RV32I decode stage: opcode constants, ALU
// operation codes, immediate/write-back selectors, the registered control
// bundle and the decode-stage FSM states.
// Optional feature macro: RISCV_DECODE_MULDIV_EN (adds M-extension ALU codes).
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_AND    = 4'b0001,
        ALU_SLT    = 4'b0010,
        ALU_SUB    = 4'b0011,
        ALU_SLL    = 4'b0100,
        ALU_XOR    = 4'b0101,
        ALU_SLTU   = 4'b0110,
        ALU_SRL    = 4'b0111,
        ALU_OR     = 4'b1000,
        ALU_SRA    = 4'b1001,
        ALU_PASSB  = 4'b1010,
        ALU_MUL    = 4'b1011,
        ALU_MULH   = 4'b1100,
        ALU_MULHSU = 4'b1101,
        ALU_DIVU   = 4'b1110,
        ALU_REMU   = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stage_state_e;

    typedef struct packed {
        imm_sel_e    imm_sel;
        logic        reg_wen;
        wb_sel_e     wb_sel;
        alu_op_e     alu_sel;
        logic [2:0]  mem_rw;
        logic        mem_unsigned;
        logic        mem_en;
        logic        a_sel;
        logic        b_sel;
        logic        br_un;
        logic        is_branch;
        logic        is_jump;
        logic [2:0]  br_func3;
        logic        illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Base integer ALU op for a func3; alt selects SUB/SRA (func7[5]).
    function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// riscv_ctrl_decode
// Purely combinational RV32I instruction-to-control-bundle decoder.
// Ports:
//   instr_i     in   fetched instruction
//   ctrl_o      out  control bundle (see riscv_ctrl_pkg::ctrl_t)
//   rs1_o/rs2_o/rd_o out raw register fields
//   uses_rs1_o  out  instruction reads rs1
//   uses_rs2_o  out  instruction reads rs2
//   is_load_o   out  instruction is a legal load
// Optional feature macro: RISCV_DECODE_MULDIV_EN. When defined, R-type with
// func7=0000001 decodes MUL, MULH, MULHSU, DIVU, REMU to ALU codes 1011..1111;
// the remaining M encodings (and all of them when undefined) are illegal.
module riscv_ctrl_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic [INSTR_W-1:0]   instr_i,
    output ctrl_t                ctrl_o,
    output logic [RF_ADDR_W-1:0] rs1_o,
    output logic [RF_ADDR_W-1:0] rs2_o,
    output logic [RF_ADDR_W-1:0] rd_o,
    output logic                 uses_rs1_o,
    output logic                 uses_rs2_o,
    output logic                 is_load_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      c;
    logic       ill;
    logic       u1;
    logic       u2;
    logic       ld;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign rd_o   = instr_i[7 +: RF_ADDR_W];
    assign rs1_o  = instr_i[15 +: RF_ADDR_W];
    assign rs2_o  = instr_i[20 +: RF_ADDR_W];

    always_comb begin
        c   = CTRL_NOP;
        ill = 1'b0;
        u1  = 1'b0;
        u2  = 1'b0;
        ld  = 1'b0;
        case (opcode)
            OP_REG: begin
                u1        = 1'b1;
                u2        = 1'b1;
                c.reg_wen = 1'b1;
                c.wb_sel  = WB_ALU;
                if (f7 == F7_BASE) begin
                    c.alu_sel = alu_base(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    c.alu_sel = alu_base(f3, 1'b1);
`ifdef RISCV_DECODE_MULDIV_EN
                end else if (f7 == F7_MULDIV) begin
                    case (f3)
                        3'b000:  c.alu_sel = ALU_MUL;
                        3'b001:  c.alu_sel = ALU_MULH;
                        3'b010:  c.alu_sel = ALU_MULHSU;
                        3'b101:  c.alu_sel = ALU_DIVU;
                        3'b111:  c.alu_sel = ALU_REMU;
                        default: ill = 1'b1;
                    endcase
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            OP_IMM: begin
                u1        = 1'b1;
                c.reg_wen = 1'b1;
                c.wb_sel  = WB_ALU;
                c.b_sel   = 1'b1;
                c.imm_sel = IMM_I;
                // Shift-immediates carry func7 in the upper immediate bits.
                if (f3 == 3'b001) begin
                    if (f7 == F7_BASE) c.alu_sel = ALU_SLL;
                    else               ill = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_BASE)     c.alu_sel = ALU_SRL;
                    else if (f7 == F7_ALT) c.alu_sel = ALU_SRA;
                    else                   ill = 1'b1;
                end else begin
                    c.alu_sel = alu_base(f3, 1'b0);
                end
            end
            OP_LOAD: begin
                u1             = 1'b1;
                ld             = 1'b1;
                c.reg_wen      = 1'b1;
                c.wb_sel       = WB_MEM;
                c.mem_en       = 1'b1;
                c.b_sel        = 1'b1;
                c.imm_sel      = IMM_I;
                c.mem_rw       = {1'b0, f3[1:0]};
                c.mem_unsigned = f3[2];
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
            end
            OP_STORE: begin
                u1        = 1'b1;
                u2        = 1'b1;
                c.mem_en  = 1'b1;
                c.b_sel   = 1'b1;
                c.imm_sel = IMM_S;
                c.mem_rw  = {1'b1, f3[1:0]};
                if (f3[2] || f3 == 3'b011) ill = 1'b1;
            end
            OP_BRANCH: begin
                u1          = 1'b1;
                u2          = 1'b1;
                c.imm_sel   = IMM_B;
                c.a_sel     = 1'b1;
                c.b_sel     = 1'b1;
                c.is_branch = 1'b1;
                c.br_un     = f3[1];
                c.br_func3  = f3;
                if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
            end
            OP_JAL: begin
                c.imm_sel = IMM_J;
                c.a_sel   = 1'b1;
                c.b_sel   = 1'b1;
                c.wb_sel  = WB_PC4;
                c.reg_wen = 1'b1;
                c.is_jump = 1'b1;
            end
            OP_JALR: begin
                u1        = 1'b1;
                c.imm_sel = IMM_I;
                c.b_sel   = 1'b1;
                c.wb_sel  = WB_PC4;
                c.reg_wen = 1'b1;
                c.is_jump = 1'b1;
                if (f3 != 3'b000) ill = 1'b1;
            end
            OP_LUI: begin
                c.imm_sel = IMM_U;
                c.b_sel   = 1'b1;
                c.alu_sel = ALU_PASSB;
                c.wb_sel  = WB_ALU;
                c.reg_wen = 1'b1;
            end
            OP_AUIPC: begin
                c.imm_sel = IMM_U;
                c.a_sel   = 1'b1;
                c.b_sel   = 1'b1;
                c.wb_sel  = WB_ALU;
                c.reg_wen = 1'b1;
            end
            OP_FENCE: begin
                // Single-issue in-order pipe: fence has nothing to order.
            end
            default: ill = 1'b1;
        endcase

        if (rd_o == '0) c.reg_wen = 1'b0;

        // Illegal instructions must have no side effects and no hazard.
        if (ill) begin
            c         = CTRL_NOP;
            c.illegal = 1'b1;
            u1        = 1'b0;
            u2        = 1'b0;
            ld        = 1'b0;
        end
    end

    assign ctrl_o     = c;
    assign uses_rs1_o = u1;
    assign uses_rs2_o = u2;
    assign is_load_o  = ld;

endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
// Registered RV32I decode stage between fetch and execute. Holds the decoded
// control bundle with valid/ready handshakes on both sides, stalls on
// load-use hazards and resolves branch redirects from execute flags.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        fetch handshake, instruction
//   flush                    drop held and incoming instruction
//   out_valid/out_ready      execute handshake
//   BrEq, BrLT               comparator flags for the held instruction
//   BrUn, ImmSel, RegWEn, WBSel, ALUSel, MemRW, mem_unsigned, mem_en,
//   ASel, BSel, rs1, rs2, rd, illegal   held control bundle
//   PCSel                    redirect PC (combinational, gated by out_valid)
// Optional feature macro: RISCV_DECODE_MULDIV_EN (see riscv_ctrl_decode).
//
// state    | meaning
// ST_RUN   | accepting instructions (subject to handshake and hazard)
// ST_STALL | inserting load-use bubbles, in_ready held low
module riscv_decode_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTR_W      = 32,
    parameter int RF_ADDR_W    = 5,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 BrEq,
    input  logic                 BrLT,
    output logic                 BrUn,
    output logic [2:0]           ImmSel,
    output logic                 RegWEn,
    output logic [1:0]           WBSel,
    output logic [3:0]           ALUSel,
    output logic [2:0]           MemRW,
    output logic                 mem_unsigned,
    output logic                 mem_en,
    output logic                 ASel,
    output logic                 BSel,
    output logic [RF_ADDR_W-1:0] rs1,
    output logic [RF_ADDR_W-1:0] rs2,
    output logic [RF_ADDR_W-1:0] rd,
    output logic                 PCSel,
    output logic                 illegal
);

    localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_BUBBLES - 1);

    ctrl_t                dec_ctrl;
    logic [RF_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic                 dec_uses_rs1, dec_uses_rs2, dec_is_load;

    riscv_ctrl_decode #(
        .INSTR_W   (INSTR_W),
        .RF_ADDR_W (RF_ADDR_W)
    ) u_decode (
        .instr_i    (instruction),
        .ctrl_o     (dec_ctrl),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .rd_o       (dec_rd),
        .uses_rs1_o (dec_uses_rs1),
        .uses_rs2_o (dec_uses_rs2),
        .is_load_o  (dec_is_load)
    );

    stage_state_e         state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 ld_vld_q, ld_vld_d;
    logic [RF_ADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic                 valid_q, valid_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic [RF_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

    logic hazard;
    logic in_xfer;
    logic br_taken;

    assign hazard = in_valid && ld_vld_q &&
                    ((dec_uses_rs1 && dec_rs1 == ld_rd_q) ||
                     (dec_uses_rs2 && dec_rs2 == ld_rd_q));

    assign in_ready = !flush && (state_q == ST_RUN) && (!valid_q || out_ready) && !hazard;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_vld_d = ld_vld_q;
        ld_rd_d  = ld_rd_q;
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;

        if (flush) begin
            valid_d  = 1'b0;
            state_d  = ST_RUN;
            cnt_d    = 2'd0;
            ld_vld_d = 1'b0;
        end else begin
            if (in_xfer) begin
                valid_d  = 1'b1;
                ctrl_d   = dec_ctrl;
                rs1_d    = dec_rs1;
                rs2_d    = dec_rs2;
                rd_d     = dec_rd;
                ld_vld_d = dec_is_load && (dec_rd != '0);
                ld_rd_d  = dec_rd;
            end else if (!(valid_q && !out_ready)) begin
                valid_d = 1'b0;
            end

            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        state_d = ST_STALL;
                        cnt_d   = BUBBLE_INIT;
                    end
                end
                ST_STALL: begin
                    // The hazard cycle itself counts as the first bubble, so
                    // leave as the counter reaches zero rather than after it.
                    if (cnt_q <= 2'd1) begin
                        state_d  = ST_RUN;
                        cnt_d    = 2'd0;
                        ld_vld_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= 2'd0;
            ld_vld_q <= 1'b0;
            ld_rd_q  <= '0;
            valid_q  <= 1'b0;
            ctrl_q   <= CTRL_NOP;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_vld_q <= ld_vld_d;
            ld_rd_q  <= ld_rd_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        case (ctrl_q.br_func3)
            3'b000:  br_taken = BrEq;
            3'b001:  br_taken = !BrEq;
            3'b100:  br_taken = BrLT;
            3'b101:  br_taken = !BrLT;
            3'b110:  br_taken = BrLT;
            3'b111:  br_taken = !BrLT;
            default: br_taken = 1'b0;
        endcase
    end

    assign PCSel = valid_q && (ctrl_q.is_jump || (ctrl_q.is_branch && br_taken));

    assign out_valid    = valid_q;
    assign BrUn         = ctrl_q.br_un;
    assign ImmSel       = ctrl_q.imm_sel;
    assign RegWEn       = ctrl_q.reg_wen;
    assign WBSel        = ctrl_q.wb_sel;
    assign ALUSel       = ctrl_q.alu_sel;
    assign MemRW        = ctrl_q.mem_rw;
    assign mem_unsigned = ctrl_q.mem_unsigned;
    assign mem_en       = ctrl_q.mem_en;
    assign ASel         = ctrl_q.a_sel;
    assign BSel         = ctrl_q.b_sel;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign rd           = rd_q;
    assign illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
module tb_riscv_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        BrEq, BrLT, BrUn;
    logic [2:0]  ImmSel;
    logic        RegWEn;
    logic [1:0]  WBSel;
    logic [3:0]  ALUSel;
    logic [2:0]  MemRW;
    logic        mem_unsigned, mem_en, ASel, BSel;
    logic [4:0]  rs1, rs2, rd;
    logic        PCSel, illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_decode_stage #(
        .INSTR_W      (32),
        .RF_ADDR_W    (5),
        .LOAD_BUBBLES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .BrEq         (BrEq),
        .BrLT         (BrLT),
        .BrUn         (BrUn),
        .ImmSel       (ImmSel),
        .RegWEn       (RegWEn),
        .WBSel        (WBSel),
        .ALUSel       (ALUSel),
        .MemRW        (MemRW),
        .mem_unsigned (mem_unsigned),
        .mem_en       (mem_en),
        .ASel         (ASel),
        .BSel         (BSel),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .PCSel        (PCSel),
        .illegal      (illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        ill;
        logic [2:0]  imm;
        logic        rwe;
        logic [1:0]  wb;
        logic [3:0]  alu;
        logic [2:0]  mrw;
        logic        mun;
        logic        men;
        logic        asel;
        logic        bsel;
        logic        brun;
        logic        pcs;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] pack_exp(input vec_t v);
        return {v.ill, v.imm, v.rwe, v.wb, v.alu, v.mrw, v.mun, v.men,
                v.asel, v.bsel, v.brun, v.pcs, v.rd};
    endfunction

    function automatic logic [24:0] pack_act();
        return {illegal, ImmSel, RegWEn, WBSel, ALUSel, MemRW, mem_unsigned, mem_en,
                ASel, BSel, BrUn, PCSel, rd};
    endfunction

    initial begin
        //            name      instr          ill imm rwe wb alu  mrw mun men as bs bu pc rd
        vecs.push_back('{"add",    32'h002081B3, 0, 0, 1, 1, 4'd0,  0, 0, 0, 0, 0, 0, 0, 3});
        vecs.push_back('{"sub",    32'h402081B3, 0, 0, 1, 1, 4'd3,  0, 0, 0, 0, 0, 0, 0, 3});
        vecs.push_back('{"sra",    32'h4020D233, 0, 0, 1, 1, 4'd9,  0, 0, 0, 0, 0, 0, 0, 4});
        vecs.push_back('{"sltu",   32'h0020B2B3, 0, 0, 1, 1, 4'd6,  0, 0, 0, 0, 0, 0, 0, 5});
        vecs.push_back('{"addi",   32'h00500093, 0, 0, 1, 1, 4'd0,  0, 0, 0, 0, 1, 0, 0, 1});
        vecs.push_back('{"srai",   32'h4030D113, 0, 0, 1, 1, 4'd9,  0, 0, 0, 0, 1, 0, 0, 2});
        vecs.push_back('{"slli_bad",32'h40309113,1, 0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 2});
        vecs.push_back('{"lw",     32'h0000A283, 0, 0, 1, 0, 4'd0,  2, 0, 1, 0, 1, 0, 0, 5});
        vecs.push_back('{"lhu",    32'h0040D303, 0, 0, 1, 0, 4'd0,  1, 1, 1, 0, 1, 0, 0, 6});
        vecs.push_back('{"sw",     32'h0020A423, 0, 1, 0, 0, 4'd0,  6, 0, 1, 0, 1, 0, 0, 8});
        vecs.push_back('{"beq_nt", 32'h00208463, 0, 2, 0, 0, 4'd0,  0, 0, 0, 1, 1, 0, 0, 8});
        vecs.push_back('{"jal",    32'h010000EF, 0, 3, 1, 2, 4'd0,  0, 0, 0, 1, 1, 0, 1, 1});
        vecs.push_back('{"jalr_x0",32'h00008067, 0, 0, 0, 2, 4'd0,  0, 0, 0, 0, 1, 0, 1, 0});
        vecs.push_back('{"lui",    32'h123453B7, 0, 4, 1, 1, 4'd10, 0, 0, 0, 0, 1, 0, 0, 7});
        vecs.push_back('{"auipc",  32'h00001417, 0, 4, 1, 1, 4'd0,  0, 0, 0, 1, 1, 0, 0, 8});
        vecs.push_back('{"fence",  32'h0000000F, 0, 0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{"bad_op", 32'hFFFFFFFF, 1, 0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 31});
        vecs.push_back('{"add_x0", 32'h00208033, 0, 0, 0, 1, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{"bltu_nt",32'h0020E463, 0, 2, 0, 0, 4'd0,  0, 0, 0, 1, 1, 1, 0, 8});
`ifdef RISCV_DECODE_MULDIV_EN
        vecs.push_back('{"mul",    32'h022081B3, 0, 0, 1, 1, 4'd11, 0, 0, 0, 0, 0, 0, 0, 3});
`else
        vecs.push_back('{"mul",    32'h022081B3, 1, 0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 3});
`endif

        rst_n = 1'b0; in_valid = 1'b0; instruction = 32'h0; flush = 1'b0;
        out_ready = 1'b1; BrEq = 1'b0; BrLT = 1'b0;
        instruction = 32'h002081B3;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bundle", 32'(pack_act()), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Decode table: one instruction per slot, flushed afterwards so load
        // tracking never couples neighbouring vectors.
        foreach (vecs[i]) begin
            in_valid = 1'b1; instruction = vecs[i].instr; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            #1;
            chk({"vld_", vecs[i].name}, 32'(out_valid), 32'd1);
            chk({"dec_", vecs[i].name}, 32'(pack_act()), 32'(pack_exp(vecs[i])));
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end

        // Load-use with two bubbles: LW x5 then ADD x6,x5,x2.
        in_valid = 1'b1; instruction = 32'h0000A283; out_ready = 1'b1;
        tick();
        instruction = 32'h00228333;
        #1;
        chk("lu_lw_valid", 32'(out_valid), 32'd1);
        chk("lu_lw_rd", 32'(rd), 32'd5);
        chk("lu_ready_c1", 32'(in_ready), 32'd0);
        tick();
        chk("lu_gap1", 32'(out_valid), 32'd0);
        chk("lu_ready_c2", 32'(in_ready), 32'd0);
        tick();
        chk("lu_gap2", 32'(out_valid), 32'd0);
        chk("lu_ready_c3", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("lu_add_valid", 32'(out_valid), 32'd1);
        chk("lu_add_rd", 32'(rd), 32'd6);
        flush = 1'b1; tick(); flush = 1'b0;

        // Branch resolution on a held BLTU, then BNE.
        in_valid = 1'b1; instruction = 32'h0020E463;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; BrLT = 1'b1;
        #1;
        chk("bltu_brun", 32'(BrUn), 32'd1);
        chk("bltu_taken", 32'(PCSel), 32'd1);
        BrLT = 1'b0;
        #1;
        chk("bltu_not_taken", 32'(PCSel), 32'd0);
        flush = 1'b1; BrLT = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("pcsel_gated", 32'(PCSel), 32'd0);
        BrLT = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; instruction = 32'h00209463;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; BrEq = 1'b0;
        #1;
        chk("bne_taken", 32'(PCSel), 32'd1);
        chk("bne_brun", 32'(BrUn), 32'd0);
        BrEq = 1'b1;
        #1;
        chk("bne_not_taken", 32'(PCSel), 32'd0);
        BrEq = 1'b0; flush = 1'b1; tick(); flush = 1'b0; out_ready = 1'b1;

        // Backpressure: ADDI held 3 cycles while ADD waits, then both in order.
        in_valid = 1'b1; instruction = 32'h00500093;
        tick();
        instruction = 32'h002081B3; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_rd%0d", k), 32'(rd), 32'd1);
            chk($sformatf("bp_hold_bsel%0d", k), 32'(BSel), 32'd1);
            chk($sformatf("bp_ready%0d", k), 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rd", 32'(rd), 32'd1);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_rd", 32'(rd), 32'd3);
        chk("bp_second_bsel", 32'(BSel), 32'd0);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush during STALL.
        in_valid = 1'b1; instruction = 32'h0000A283;
        tick();
        instruction = 32'h00228333;
        tick();
        flush = 1'b1;
        #1;
        chk("fl_ready_during", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_ready_after", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("fl_add_rd", 32'(rd), 32'd6);
        flush = 1'b1; tick(); flush = 1'b0;

        // Flush coinciding with a hazard cycle: flush wins.
        in_valid = 1'b1; instruction = 32'h0000A283;
        tick();
        instruction = 32'h00228333; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flhz_ready", 32'(in_ready), 32'd1);
        chk("flhz_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;

        // Reset in the middle of a stall.
        in_valid = 1'b1; instruction = 32'h0000A283;
        tick();
        instruction = 32'h00228333;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rststall_valid", 32'(out_valid), 32'd0);
        chk("rststall_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
